bcd_stopwatch_ctrl: RTL
=======================

# bcd_stopwatch_ctrl

Four-digit BCD stopwatch controller that sequences a cascaded chain of mod-10 counters. It has a start/stop/clear/lap command FSM and a programmable tick prescaler. The block replaces free-running single-digit BCD counters in the timer subsystem. It produces a live count and a lap-freezable display value for the seven-segment driver.

## Interface
- TICK_DIV, default 10: clock cycles per count increment; legal range is 2..65535.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level sampled each cycle; launches counting from IDLE or resumes from PAUSE.
- stop  input  1  level sampled each cycle; moves RUN to PAUSE.
- clear  input  1  level sampled each cycle; returns to IDLE and zeroes all state.
- lap  input  1  level sampled each cycle; toggles the display freeze while in RUN.
- count  output  16  live value as four BCD digits; [15:12] is the most significant.
- disp  output  16  display value: equals count, or the frozen lap snapshot.
- running  output  1  high while in RUN.
- tick  output  1  one-cycle pulse marking the cycle in which count increments.
- overflow  output  1  sticky flag, set when 9999 rolls over.

## Operation
- FSM states: IDLE, RUN, PAUSE.
- Command priority, when several are high in the same cycle: clear > stop > start > lap.
- IDLE:
  - count = 0000, prescaler = 0, lap freeze off, overflow = 0.
  - start -> RUN.
  - stop and lap are ignored.
- RUN:
  - The prescaler counts 0..TICK_DIV-1.
  - When it reaches TICK_DIV-1: tick = 1, the prescaler returns to 0, and count increments.
  - stop -> PAUSE.
  - clear -> IDLE.
  - start is ignored.
- PAUSE:
  - The prescaler and count are held.
  - start -> RUN; the prescaler resumes from its held value.
  - clear -> IDLE.
  - lap is ignored; the freeze state is held.
- BCD increment:
  - Digit 0 increments on tick.
  - A digit at 9 wraps to 0 and carries into the next digit in the same cycle.
  - Digit values 10..15 never occur.
- Rollover from 9999 is set by configuration (see Configuration).
- Lap:
  - In RUN with freeze off, lap copies count into the lap register and sets freeze on.
  - In RUN with freeze on, lap clears freeze.
  - disp = lap register while freeze is on, otherwise count.
  - If lap coincides with tick, the snapshot takes the pre-increment count.
- Held commands:
  - Commands are levels, not edges.
  - A held lap toggles the freeze every cycle. Requesters must pulse lap for one cycle.
- clear while frozen releases the freeze and zeroes the lap register.

## Timing
- Reset values: state = IDLE, count = 0000, disp = 0000, lap register = 0000, prescaler = 0, running = 0, tick = 0, overflow = 0.
- All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.
- start sampled at edge E:
  - running = 1 after E.
  - From IDLE, the first tick is high in the cycle ending at edge E+TICK_DIV.
  - count shows 0001 after edge E+TICK_DIV.
- stop sampled at edge E: running = 0 after E. No tick occurs after E, even if the prescaler was at TICK_DIV-1.
- tick is high in the cycle before the edge that updates count.
- lap sampled at edge E: disp is frozen after E.
- Asynchronous rst mid-count returns all outputs to reset values immediately. Operation resumes in IDLE at the first edge after rst falls.

## Configuration
- STOPWATCH_SATURATE_EN defined:
  - On the tick at 9999, count stays 9999.
  - overflow sets.
  - The FSM moves to PAUSE and running drops after that edge.
  - start in PAUSE is ignored while overflow = 1; only clear exits.
- STOPWATCH_SATURATE_EN not defined:
  - 9999 wraps to 0000 on tick and overflow sets.
  - The FSM stays in RUN.
  - overflow stays set until clear or rst.

## Test plan
- Reset then start with TICK_DIV = 4: tick every 4th cycle. count = 0001 at 4 cycles after start and 0010 at 40 cycles.
- With count = 0199, run one tick: count = 0200, with the carry across two digits in a single cycle.
- start, then stop after 3 ticks, wait 20 cycles, then start again: count holds 0003 during PAUSE. The next tick arrives after the remaining prescaler cycles, not a full TICK_DIV.
- Run to count = 0025, pulse lap, run 10 ticks, pulse lap:
  - disp = 0025 while count = 0035.
  - After the second lap, disp = 0035.
- Preload 9998 via ticks and run 2 ticks:
  - Macro off: count = 0000, overflow = 1, running = 1.
  - Macro on: count = 9999, overflow = 1, running = 0.
- Simultaneous clear + start in RUN: IDLE with count = 0000. Then assert rst mid-tick-interval: all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command and display bundle for the four-digit BCD stopwatch controller.
// Commands are plain levels sampled every clock; there is no valid/ready pairing.
interface bcd_stopwatch_ctrl_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        lap;
  logic [15:0] count;
  logic [15:0] disp;
  logic        running;
  logic        tick;
  logic        overflow;
  logic [1:0]  dbg_state;

  modport master (
    output start, stop, clear, lap,
    input  count, disp, running, tick, overflow, dbg_state
  );

  modport slave (
    input  start, stop, clear, lap,
    output count, disp, running, tick, overflow, dbg_state
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch: IDLE/RUN/PAUSE command FSM, tick prescaler, lap freeze.
// Optional macro STOPWATCH_SATURATE_EN: hold at 9999 and pause instead of wrapping.
module bcd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 10
) (
  input logic                clk,
  input logic                rst,
  bcd_stopwatch_ctrl_if.slave sw
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] count_q, count_d;
  logic [15:0] lap_q, lap_d;
  logic        frz_q, frz_d;
  logic        ovf_q, ovf_d;
  logic        tick_w;
  logic        all_nines;

  // Ripple the carry through the digits so multi-digit carries land in one cycle.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Decoded purely from registers, so no input reaches tick combinationally.
  assign tick_w    = (state_q == S_RUN) && (presc_q == PRESC_MAX);
  assign all_nines = (count_q == 16'h9999);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= 16'd0;
      count_q <= 16'h0000;
      lap_q   <= 16'h0000;
      frz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      lap_q   <= lap_d;
      frz_q   <= frz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    lap_d   = lap_q;
    frz_d   = frz_q;
    ovf_d   = ovf_q;

    if (sw.clear) begin
      state_d = S_IDLE;
      presc_d = 16'd0;
      count_d = 16'h0000;
      lap_d   = 16'h0000;
      frz_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sw.start) state_d = S_RUN;
        end

        S_RUN: begin
          // The cycle ending at a stop edge was still a RUN cycle and counts.
          if (tick_w) begin
            presc_d = 16'd0;
            if (all_nines) begin
              ovf_d = 1'b1;
`ifdef STOPWATCH_SATURATE_EN
              state_d = S_PAUSE;
`else
              count_d = 16'h0000;
`endif
            end else begin
              count_d = bcd_inc(count_q);
            end
          end else begin
            presc_d = presc_q + 16'd1;
          end

          if (sw.stop) begin
            state_d = S_PAUSE;
          end else if (sw.lap) begin
            // Snapshot takes count_q, i.e. the pre-increment value on a tick edge.
            if (frz_q) begin
              frz_d = 1'b0;
            end else begin
              frz_d = 1'b1;
              lap_d = count_q;
            end
          end
        end

        S_PAUSE: begin
`ifdef STOPWATCH_SATURATE_EN
          if (sw.start && !ovf_q) state_d = S_RUN;
`else
          if (sw.start) state_d = S_RUN;
`endif
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign sw.count     = count_q;
  assign sw.disp      = frz_q ? lap_q : count_q;
  assign sw.running   = (state_q == S_RUN);
  assign sw.tick      = tick_w;
  assign sw.overflow  = ovf_q;
  assign sw.dbg_state = state_q;

endmodule
